// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Holds default geometry, the clear/run state encoding and the
// write-port priority order (lower index wins a same-address collision).
package regfile_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_LINK_REG = 31;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    // Write-port priority: index 0 is the strongest writer.
    localparam int WP_PORT1 = 0;
    localparam int WP_PORT0 = 1;
    localparam int WP_LINK  = 2;
    localparam int RF_NWP   = 3;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer for the register file.
// After reset it walks idx = 1 .. 2**ADDR_W-1, asserting a zeroing strobe
// for one entry per clock, then enters RUN and raises ready.
// Ports:
//   clk_i      - clock
//   rst_i      - synchronous active-high reset, restarts the sequence
//   ready_o    - registered, high once every entry has been zeroed
//   clr_we_o   - zero-write strobe for entry clr_addr_o
//   clr_addr_o - entry being zeroed this cycle
//
// state    | meaning
// RF_CLEAR | zeroing entry idx each edge, writes/reads blocked
// RF_RUN   | clear finished, array usable
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              ready_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = '1;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RF_CLEAR;
            idx_q   <= IDX_FIRST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == RF_CLEAR) begin
            if (idx_q == IDX_LAST) begin
                state_d = RF_RUN;
            end else begin
                idx_d = idx_q + IDX_FIRST;
            end
        end
    end

    // ready comes straight from the state flop, so it cannot glitch.
    assign ready_o    = (state_q == RF_RUN);
    // No array write on a reset edge, even while clearing.
    assign clr_we_o   = (state_q == RF_CLEAR) && !rst_i;
    assign clr_addr_o = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports, two general
// write ports and a link-register write port, with optional same-cycle
// write-to-read bypass. Entry 0 has no storage and reads as zero.
// Ports:
//   Clock, Reset            - clock, synchronous active-high reset
//   Ra/Rb -> busA/busB      - combinational reads
//   Rw0/Write0/busW0        - write port 0
//   Rw1/Write1/busW1        - write port 1 (highest priority)
//   LinkWrite/LinkData      - writes LINK_REG (lowest priority)
//   r_Link                  - stored LINK_REG value, never bypassed
//   Ready                   - array cleared and usable
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int LINK_REG = RF_LINK_REG,
    parameter int BYPASS   = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    input  logic [ADDR_W-1:0] Rw0,
    input  logic              Write0,
    input  logic [DATA_W-1:0] busW0,
    input  logic [ADDR_W-1:0] Rw1,
    input  logic              Write1,
    input  logic [DATA_W-1:0] busW1,
    input  logic              LinkWrite,
    input  logic [DATA_W-1:0] LinkData,
    output logic [DATA_W-1:0] r_Link,
    output logic              Ready
);

    localparam int                NREGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    logic              ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    regfile_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clr (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .ready_o    (ready),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    logic [DATA_W-1:0] regs_q [1:NREGS-1];
    logic [DATA_W-1:0] regs_d [1:NREGS-1];

    // Writers gathered in priority order; an enable here means the write
    // will actually commit on the coming edge.
    logic [RF_NWP-1:0] wr_en;
    logic [ADDR_W-1:0] wr_addr [RF_NWP];
    logic [DATA_W-1:0] wr_data [RF_NWP];

    always_comb begin
        wr_addr[WP_PORT1] = Rw1;
        wr_addr[WP_PORT0] = Rw0;
        wr_addr[WP_LINK]  = LINK_A;
        wr_data[WP_PORT1] = busW1;
        wr_data[WP_PORT0] = busW0;
        wr_data[WP_LINK]  = LinkData;
        wr_en[WP_PORT1]   = ready && !Reset && Write1 && (Rw1 != '0);
        wr_en[WP_PORT0]   = ready && !Reset && Write0 && (Rw0 != '0);
        wr_en[WP_LINK]    = ready && !Reset && LinkWrite;
    end

    // Apply weakest writer first so the strongest one lands last.
    always_comb begin
        regs_d = regs_q;
        if (clr_we) begin
            regs_d[clr_addr] = '0;
        end
        for (int p = RF_NWP - 1; p >= 0; p--) begin
            if (wr_en[p]) begin
                regs_d[wr_addr[p]] = wr_data[p];
            end
        end
    end

    // No reset on the array: the clear sequencer zeroes it instead.
    always_ff @(posedge Clock) begin
        regs_q <= regs_d;
    end

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    always_comb begin
        rd_addr[0] = Ra;
        rd_addr[1] = Rb;
        for (int r = 0; r < 2; r++) begin
            rd_data[r] = '0;
            if (ready && (rd_addr[r] != '0)) begin
                rd_data[r] = regs_q[rd_addr[r]];
                if (BYPASS != 0) begin
                    for (int p = RF_NWP - 1; p >= 0; p--) begin
                        if (wr_en[p] && (wr_addr[p] == rd_addr[r])) begin
                            rd_data[r] = wr_data[p];
                        end
                    end
                end
            end
        end
    end

    assign busA   = rd_data[0];
    assign busB   = rd_data[1];
    assign r_Link = ready ? regs_q[LINK_A] : '0;
    assign Ready  = ready;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Multi-port register file for the next-generation datapath: two combinational read ports, two general write ports and a dedicated link-register write port, with optional same-cycle write-to-read bypass. After reset, a clear sequencer zeroes the array one entry per clock and holds `Ready` low until every entry is zero. Register 0 reads as zero at all times. The block sits between decode (read addresses), writeback (ports 0/1) and the PC/jump unit (link port).

## Interface
- `DATA_W`, 32: register and bus width.
- `ADDR_W`, 5: address width; depth `NREGS = 2**ADDR_W` (derived, not overridable).
- `LINK_REG`, 31: index of the link register; must be in 1..NREGS-1.
- `BYPASS`, 1: 1 = reads return same-cycle write data; 0 = reads return stored value only.

Ports:
- `Clock` in 1: single clock; all state updates on rising edge.
- `Reset` in 1: synchronous, active-high.
- `Ra` in ADDR_W: read address A.
- `Rb` in ADDR_W: read address B.
- `busA` out DATA_W: read data A.
- `busB` out DATA_W: read data B.
- `Rw0` in ADDR_W: write address, port 0.
- `Write0` in 1: write enable, port 0.
- `busW0` in DATA_W: write data, port 0.
- `Rw1` in ADDR_W: write address, port 1.
- `Write1` in 1: write enable, port 1.
- `busW1` in DATA_W: write data, port 1.
- `LinkWrite` in 1: write enable, link port; target is fixed at `LINK_REG`.
- `LinkData` in DATA_W: link write data.
- `r_Link` out DATA_W: stored value of `LINK_REG`, no bypass.
- `Ready` out 1: 1 = clear finished and array usable.

## Operation
- State machine with two states. CLEAR: clear counter `idx` walks 1..NREGS-1 and writes zero to `Register[idx]` each edge. RUN: normal operation.
- `Reset` high: next state is CLEAR with `idx = 1`, applied every edge while `Reset` is held. No array write occurs on a reset edge.
- In CLEAR with `Reset` low: each edge zeroes `Register[idx]` and increments `idx`. The edge that zeroes `NREGS-1` moves the machine to RUN.
- `Reset` asserted mid-clear restarts the sequence at `idx = 1`.
- In CLEAR, all write enables are ignored. `busA`, `busB` and `r_Link` read 0.
- In RUN, an enabled write with nonzero address updates the register at the edge. Writes to address 0 are discarded.
- Same-edge collisions on one address have fixed priority: port 1 > port 0 > link. Only the highest-priority value is stored.
- Writes to different addresses in the same cycle all commit.
- Reads with address 0 return 0.
- Reads with `BYPASS = 1` in RUN: if any enabled writer targets the read address, the read returns that writer's data, chosen by the same priority order. Otherwise the read returns the stored value.
- Reads with `BYPASS = 0`: always the stored value.

## Timing
- Reads are combinational (zero latency). A write is visible through the stored-value path from the cycle after its edge.
- Reset outputs: `Ready = 0`, state CLEAR. `busA`, `busB` and `r_Link` are 0 for the whole clear sequence.
- Clear duration: `Ready` rises after exactly NREGS-1 edges with `Reset` low (31 edges for ADDR_W = 5).
- `Ready` is registered and glitch-free. It stays high until the next `Reset`.
- The clear sequence zeroes every entry, so array contents after `Ready` never depend on pre-reset values.

## Structure
- Shared package `regfile_pkg`: default `DATA_W`, `ADDR_W`, `LINK_REG`; state encoding `RF_CLEAR = 1'b0`, `RF_RUN = 1'b1`; write-port priority constants.
- Sub-module `regfile_clear_ctrl` contains the state register, the `idx` counter, `Ready`, and the clear-write strobe and address.
- Top level contains:
  - the array, sized 1..NREGS-1, with no storage for entry 0;
  - the write-priority merge;
  - the bypass muxes.

## Test plan
- Reset held 3 cycles, then released with the array pre-loaded with 0xFFFFFFFF: `Ready` is 0 for 31 edges and 1 after the 31st. Afterwards every register reads 0x00000000, and reads during the clear return 0.
- Mid-clear reset: assert `Reset` for 1 cycle after 10 clear edges. `Ready` rises exactly 31 edges after the release, not 21.
- Collision: `Rw0 = Rw1 = 31`, `busW0 = 0xAAAA0000`, `busW1 = 0x5555FFFF`, `LinkWrite = 1`, `LinkData = 0x12345678`. Next cycle `r_Link = 0x5555FFFF`. Repeat with `Write1 = 0`: `r_Link = 0xAAAA0000`.
- Bypass: with `BYPASS = 1`, `Ra = 7`, `Write0 = 1`, `Rw0 = 7`, `busW0 = 0xDEADBEEF`, register 7 holding 0. `busA = 0xDEADBEEF` in the same cycle. With `BYPASS = 0`, `busA = 0` that cycle and 0xDEADBEEF the next.
- Zero register: `Write1 = 1`, `Rw1 = 0`, `busW1 = 0xFFFFFFFF`. `Ra = Rb = 0` reads 0 in both the write cycle and the following cycle.
- Parallel writes: port 0 writes reg 3 = 0x3, port 1 writes reg 4 = 0x4, link writes 0x1F, all in one cycle. Next cycle `Ra = 3` gives 0x3, `Rb = 4` gives 0x4, `r_Link = 0x1F`. Repeat with `DATA_W = 16`, `ADDR_W = 3`: `Ready` rises after 7 edges.
